// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the system reset; retries on timeout, restarts on loss.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRY_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               sw_reset,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               sys_ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  typedef enum logic [1:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RUN
  } state_t;

  localparam logic [19:0] LP_RST_LAST =
    20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] LP_LOCK_LAST =
    20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] LP_STB_LAST =
    20'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] LP_RETRY_MAX =
    {RETRY_W{1'b1}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [19:0]        r_cnt;
  logic               r_sync1;
  logic               r_sync2;
  logic               w_locked_s;
  logic               w_restart;
  logic               w_retry_inc;
  logic               w_lost_set;
  logic               r_pll_rst;
  logic               r_sys_reset;
  logic               r_sys_ready;
  logic [RETRY_W-1:0] r_retry;
  logic               r_lost;

  assign w_locked_s = r_sync2;

  // Two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state decode; a software restart beats every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_retry_inc = 1'b0;
    w_lost_set  = 1'b0;
    if (sw_reset) begin
      w_state_nxt = S_PLLRST;
      w_restart   = 1'b1;
    end else begin
      unique case (r_state)
        S_PLLRST: begin
          if (r_cnt == LP_RST_LAST)
            w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
          end else if (r_cnt == LP_LOCK_LAST) begin
            w_state_nxt = S_PLLRST;
            w_retry_inc = 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_locked_s)
            w_state_nxt = S_WAIT;
          else if (r_cnt == LP_STB_LAST)
            w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = S_PLLRST;
            w_lost_set  = 1'b1;
          end
        end
        default: w_state_nxt = S_PLLRST;
      endcase
    end
  end

  // State register and shared cycle counter (restarts on every entry)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLLRST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart || (w_state_nxt != r_state) ||
          (w_state_nxt == S_RUN))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 20'd1;
    end
  end

  // Registered outputs decoded from the next state, so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_sys_ready <= 1'b0;
    end else begin
      r_pll_rst   <= (w_state_nxt == S_PLLRST);
      r_sys_reset <= (w_state_nxt != S_RUN);
      r_sys_ready <= (w_state_nxt == S_RUN);
    end
  end

  // Saturating timeout counter and sticky lock-lost flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
      r_lost  <= 1'b0;
    end else begin
      if (w_retry_inc && (r_retry != LP_RETRY_MAX))
        r_retry <= r_retry + RETRY_W'(1);
      if (w_lost_set)
        r_lost <= 1'b1;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_reset = r_sys_reset;
  assign sys_ready = r_sys_ready;
  assign retry_cnt = r_retry;
  assign lock_lost = r_lost;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/age reference model feeds a
// scoreboard queue; a monitor pops and compares after each clock edge.
module tb_pll_reset_sequencer;

  localparam int P    = 4;
  localparam int T    = 32;
  localparam int S    = 8;
  localparam int RW   = 4;
  localparam int RMAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          sw_reset = 1'b0;
  logic          pll_rst;
  logic          sys_reset;
  logic          sys_ready;
  logic [RW-1:0] retry_cnt;
  logic          lock_lost;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .RETRY_W       (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .sw_reset  (sw_reset),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .sys_ready (sys_ready),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost)
  );

  typedef enum int {
    PH_PLLRST,
    PH_WAIT,
    PH_STABLE,
    PH_RUN
  } ph_t;

  typedef struct {
    bit tmo;
    bit prst;
    bit srst;
    bit rdy;
    int retry;
    bit lost;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;

  ph_t  m_phase;
  int   m_age;
  int   m_retry;
  bit   m_lost;
  bit   m_hist[$];

  function automatic void m_reset();
    m_phase = PH_PLLRST;
    m_age   = 0;
    m_retry = 0;
    m_lost  = 1'b0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endfunction

  function automatic void m_enter(ph_t ph);
    m_phase = ph;
    m_age   = 0;
  endfunction

  // m_hist[0] is the newest lock sample, m_hist[1] the synchronised one
  function automatic void m_edge();
    bit ls;
    if (!rst_n) begin
      m_reset();
      return;
    end
    ls = m_hist[1];
    m_hist.push_front(pll_locked);
    void'(m_hist.pop_back());
    if (sw_reset) begin
      m_enter(PH_PLLRST);
    end else if (m_phase == PH_PLLRST) begin
      if (m_age + 1 == P) m_enter(PH_WAIT);
      else m_age++;
    end else if (m_phase == PH_WAIT) begin
      if (ls) begin
        m_enter(PH_STABLE);
      end else if (m_age + 1 == T) begin
        m_enter(PH_PLLRST);
        if (m_retry < RMAX) m_retry++;
      end else begin
        m_age++;
      end
    end else if (m_phase == PH_STABLE) begin
      if (!ls) m_enter(PH_WAIT);
      else if (m_age + 1 == S) m_enter(PH_RUN);
      else m_age++;
    end else begin
      if (!ls) begin
        m_enter(PH_PLLRST);
        m_lost = 1'b1;
      end else begin
        m_age++;
      end
    end
  endfunction

  function automatic exp_t m_exp();
    exp_t e;
    e.tmo   = 1'b0;
    e.prst  = (m_phase == PH_PLLRST);
    e.srst  = (m_phase != PH_RUN);
    e.rdy   = (m_phase == PH_RUN);
    e.retry = m_retry;
    e.lost  = m_lost;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_edge();
    sb.push_back(m_exp());
    #1;
  endtask

  task automatic async_reset();
    #4;
    rst_n = 1'b0;
    m_reset();
    sb.push_back(m_exp());
  endtask

  task automatic wait_model(input ph_t ph, input int age);
    int   n;
    exp_t e;
    n = 0;
    while (!(m_phase == ph && m_age == age) && n < 200) begin
      tick();
      n++;
    end
    if (!(m_phase == ph && m_age == age)) begin
      e = '{default: 0};
      e.tmo = 1'b1;
      sb.push_back(e);
    end
  endtask

  function automatic void chk(input string nm, input int act,
                              input int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, act, req,
               $time);
    end
  endfunction

  // Monitor: compare everything queued once outputs have settled
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #3;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.tmo) begin
          nchk++;
          nfail++;
          $display("FAIL wait_phase timed out at %0t", $time);
        end else begin
          chk("pll_rst", int'(pll_rst), int'(e.prst));
          chk("sys_reset", int'(sys_reset), int'(e.srst));
          chk("sys_ready", int'(sys_ready), int'(e.rdy));
          chk("retry_cnt", int'(retry_cnt), e.retry);
          chk("lock_lost", int'(lock_lost), int'(e.lost));
          chk("ready_and_reset", int'(sys_ready & sys_reset), 0);
          chk("pllrst_no_sysrst", int'(pll_rst & ~sys_reset), 0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int hold;
    m_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // clean bring-up, lock 10 cycles after release
    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (30) tick();

    // lock loss in RUN, then re-lock
    pll_locked = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    pll_locked = 1'b1;
    repeat (30) tick();

    // software restart from RUN
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    repeat (30) tick();

    // one-cycle glitch seen at STABLE count 5
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    wait_model(PH_STABLE, 3);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (30) tick();

    // no lock: restart coinciding with a timeout, then saturate
    pll_locked = 1'b0;
    wait_model(PH_WAIT, T - 1);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    repeat (600) tick();

    // build retry=2, lock_lost=1, then reset mid-STABLE
    async_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2 * (P + T) + 5) tick();
    pll_locked = 1'b1;
    repeat (20) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    wait_model(PH_STABLE, 3);
    async_reset();
    repeat (2) tick();
    rst_n = 1'b1;

    // randomized lock behaviour, restarts and resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = !pll_locked;
        hold = pll_locked ? $urandom_range(10, 120)
                          : $urandom_range(1, 50);
      end
      hold--;
      sw_reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    sw_reset = 1'b0;
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, pll_rst pulse length in clk cycles (1..2^20-1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, cycles waited for lock before re-pulsing pll_rst (1..2^20-1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, cycles lock must stay high before releasing system reset (1..2^20-1).
REQ-004 SHALL have parameter RETRY_W, default 4, width of retry_cnt.
REQ-005 SHALL have port clk  input  1  free-running 50 MHz board reference clock (not a PLL output).
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked  input  1  PLL lock indication, asynchronous to clk.
REQ-008 SHALL have port sw_reset  input  1  synchronous software/button restart request, active-high.
REQ-009 SHALL have port pll_rst  output  1  active-high reset to the PLL.
REQ-010 SHALL have port sys_reset  output  1  active-high reset to logic clocked by PLL outputs.
REQ-011 SHALL have port sys_ready  output  1  high only while clocks are stable and sys_reset is low.
REQ-012 SHALL have port retry_cnt  output  RETRY_W  count of lock timeouts, saturating.
REQ-013 SHALL have port lock_lost  output  1  sticky flag: lock dropped while in RUN.

Function
REQ-014 SHALL synchronise pll_locked through exactly two clk flops into locked_s; only locked_s is used internally.
REQ-015 SHALL implement states PLLRST, WAIT, STABLE, RUN with one shared 20-bit cycle counter cleared on every state change.
REQ-016 PLLRST: counter increments each cycle; on cnt == PLL_RST_CYCLES-1 -> WAIT.
REQ-017 WAIT: if locked_s -> STABLE; else on cnt == LOCK_TIMEOUT-1 -> PLLRST and retry_cnt increments, saturating at all-ones.
REQ-018 STABLE: if locked_s low -> WAIT (retry_cnt unchanged); else on cnt == STABLE_CYCLES-1 -> RUN.
REQ-019 RUN: if locked_s low -> PLLRST and lock_lost set to 1; lock_lost clears only on rst_n.
REQ-020 sw_reset high in any state SHALL force PLLRST next cycle, overriding every other transition; retry_cnt and lock_lost unaffected.
REQ-021 Outputs SHALL be driven directly from flops (no combinational decode after state): pll_rst = 1 exactly while in PLLRST, sys_reset = 1 in every state except RUN, sys_ready = 1 only in RUN.
REQ-022 pll_rst SHALL be high for exactly PLL_RST_CYCLES clk cycles per visit to PLLRST.
REQ-023 With pll_locked first sampled high at edge E and held high in WAIT, sys_reset SHALL fall and sys_ready rise at edge E+STABLE_CYCLES+2.
REQ-024 Loss of lock in RUN SHALL raise sys_reset and pll_rst, and drop sys_ready, at the third clk edge after pll_locked falls (2 sync + 1 state).
REQ-025 sys_reset and sys_ready SHALL never be high simultaneously; pll_rst high implies sys_reset high.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously set state PLLRST, counter 0, sync flops 0, pll_rst 1, sys_reset 1, sys_ready 0, retry_cnt 0, lock_lost 0.
REQ-027 After rst_n release, pll_rst SHALL stay high for PLL_RST_CYCLES cycles before the first WAIT.
REQ-028 rst_n asserted mid-sequence (any state) SHALL abort it with no residual counter or flag state.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, RETRY_W=4)
REQ-029 Clean bring-up: release rst_n, pll_locked rises 10 cycles later -> pll_rst high 4 cycles, sys_reset falls 10 edges after first locked sample, sys_ready=1, retry_cnt=0, lock_lost=0.
REQ-030 No lock: pll_locked held 0 -> pll_rst re-pulses (4 cycles) every 36 cycles; retry_cnt 1,2,...,15 then holds 15; sys_reset stays 1.
REQ-031 Glitch in STABLE: pll_locked low for 1 cycle at STABLE cnt 5 -> back to WAIT, STABLE restarts from 0, sys_reset stays 1, retry_cnt unchanged.
REQ-032 Loss in RUN: pll_locked drops -> sys_reset=1, sys_ready=0, pll_rst=1 at 3rd edge; 4-cycle pulse; lock_lost=1 and remains 1 after re-lock and return to RUN.
REQ-033 sw_reset 1-cycle pulse in RUN -> PLLRST next edge, 4-cycle pll_rst, normal re-lock; lock_lost=0, retry_cnt unchanged; sw_reset concurrent with WAIT timeout -> no retry increment.
REQ-034 rst_n low mid-STABLE (cnt 3) with retry_cnt=2, lock_lost=1 -> all outputs to REQ-026 values without a clk edge.
